// File: rtl/cpu_state_dumper_pkg.sv
// cpu_dump_pkg: shared constants and types for the CPU state dumper.
// Holds the FSM state encoding, frame header magic and word offsets.
package cpu_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CNT  = 3'd2,
    ST_REG  = 3'd3,
    ST_MEM  = 3'd4,
    ST_CHK  = 3'd5
  } state_e;

  typedef logic [5:0] widx_t;

  localparam logic [15:0] HDR_MAGIC = 16'hD0D0;

  localparam widx_t OFF_CNT = 6'd1;
  localparam widx_t OFF_REG = 6'd5;
  localparam widx_t OFF_MEM = 6'd37;
  localparam widx_t OFF_CHK = 6'd45;

`ifdef DUMP_CHECKSUM_EN
  localparam widx_t FRAME_LEN = 6'd46;
`else
  localparam widx_t FRAME_LEN = 6'd45;
`endif

endpackage

// File: rtl/cpu_state_dumper_if.sv
// Dump stream interface: 32-bit words with valid/ready and end-of-frame.
// master: dumper (drives data/valid/last); slave: host/UART bridge.
interface cpu_state_dumper_if;

  logic [31:0] dump_data_o;
  logic        dump_valid_o;
  logic        dump_ready_i;
  logic        dump_last_o;

  modport master (
    output dump_data_o,
    output dump_valid_o,
    output dump_last_o,
    input  dump_ready_i
  );

  modport slave (
    input  dump_data_o,
    input  dump_valid_o,
    input  dump_last_o,
    output dump_ready_i
  );

endinterface

// File: rtl/cpu_state_dumper_sat_counter32.sv
// sat_counter32: 32-bit event counter that sticks at all-ones.
// Ports: clk_i, rst_i (async, active-low), en_i (count), cnt_o (value).
module sat_counter32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: on start_i, streams a snapshot frame of CPU state:
// header, cycle/stall/flush counts, PC, x0..x31, dmem[0..NUM_DMEM-1].
// Ports: clk_i, rst_i (async, active-low), start_i, pc_i, stall_evt_i,
//  flush_evt_i, reg_addr_o/reg_data_i, dmem_addr_o/dmem_data_i,
//  busy_o, dump (stream master: data/valid/ready/last).
// Build option: DUMP_CHECKSUM_EN appends an XOR checksum word.
module cpu_state_dumper
  import cpu_dump_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_DMEM = 8,
  parameter int DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [31:0]       pc_i,
  input  logic              stall_evt_i,
  input  logic              flush_evt_i,
  output logic [4:0]        reg_addr_o,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [4:0]        dmem_addr_o,
  input  logic [DATA_W-1:0] dmem_data_i,
  output logic              busy_o,
  cpu_state_dumper_if.master dump
);

  localparam widx_t L_REG_END = widx_t'(OFF_REG + NUM_REGS - 1);
  localparam widx_t L_MEM_END = widx_t'(OFF_MEM + NUM_DMEM - 1);

  logic [31:0] w_cyc;
  logic [31:0] w_stall;
  logic [31:0] w_flush;

  sat_counter32 u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (1'b1),
    .cnt_o (w_cyc)
  );

  sat_counter32 u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (stall_evt_i),
    .cnt_o (w_stall)
  );

  sat_counter32 u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (flush_evt_i),
    .cnt_o (w_flush)
  );

  state_e      r_state;
  widx_t       r_nidx;
  logic [15:0] r_seq;
  logic [31:0] r_snap_cyc;
  logic [31:0] r_snap_stall;
  logic [31:0] r_snap_flush;
  logic [31:0] r_snap_pc;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_last;
  logic        r_busy;
  logic [4:0]  r_reg_addr;
  logic [4:0]  r_dmem_addr;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] r_chk;
`endif

  logic        w_load;
  logic        w_fin;
  widx_t       w_n1;
  logic [31:0] w_word;
  state_e      w_nst;
  logic [4:0]  w_raddr;
  logic [4:0]  w_maddr;

  // r_nidx is the index of the word the output register loads next.
  assign w_load = !r_valid || dump.dump_ready_i;
  assign w_fin  = r_valid && dump.dump_ready_i && r_last;
  assign w_n1   = r_nidx + 6'd1;

  always_comb begin
    w_word = '0;
    w_nst  = ST_IDLE;
    unique case (1'b1)
      (r_nidx == OFF_CNT): begin
        w_word = r_snap_cyc;
        w_nst  = ST_CNT;
      end
      (r_nidx == OFF_CNT + 6'd1): begin
        w_word = r_snap_stall;
        w_nst  = ST_CNT;
      end
      (r_nidx == OFF_CNT + 6'd2): begin
        w_word = r_snap_flush;
        w_nst  = ST_CNT;
      end
      (r_nidx == OFF_CNT + 6'd3): begin
        w_word = r_snap_pc;
        w_nst  = ST_CNT;
      end
      (r_nidx >= OFF_REG && r_nidx <= L_REG_END): begin
        w_word = reg_data_i;
        w_nst  = ST_REG;
      end
      (r_nidx >= OFF_MEM && r_nidx <= L_MEM_END): begin
        w_word = dmem_data_i;
        w_nst  = ST_MEM;
      end
`ifdef DUMP_CHECKSUM_EN
      (r_nidx == OFF_CHK): begin
        w_word = r_chk;
        w_nst  = ST_CHK;
      end
`endif
      default: begin
        w_word = '0;
        w_nst  = ST_IDLE;
      end
    endcase
  end

  // Read ports point at the word that the following load will fetch.
  always_comb begin
    w_raddr = '0;
    w_maddr = '0;
    if (w_n1 >= OFF_REG && w_n1 <= L_REG_END) begin
      w_raddr = 5'(w_n1 - OFF_REG);
    end
    if (w_n1 >= OFF_MEM && w_n1 <= L_MEM_END) begin
      w_maddr = 5'(w_n1 - OFF_MEM);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_nidx       <= '0;
      r_seq        <= '0;
      r_snap_cyc   <= '0;
      r_snap_stall <= '0;
      r_snap_flush <= '0;
      r_snap_pc    <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
      r_reg_addr   <= '0;
      r_dmem_addr  <= '0;
`ifdef DUMP_CHECKSUM_EN
      r_chk        <= '0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            // Counters are sampled before this edge's events land.
            r_snap_cyc   <= w_cyc;
            r_snap_stall <= w_stall;
            r_snap_flush <= w_flush;
            r_snap_pc    <= pc_i;
            r_data       <= {HDR_MAGIC, r_seq};
            r_valid      <= 1'b1;
            r_last       <= 1'b0;
            r_busy       <= 1'b1;
            r_nidx       <= OFF_CNT;
            r_state      <= ST_HDR;
            r_reg_addr   <= '0;
            r_dmem_addr  <= '0;
`ifdef DUMP_CHECKSUM_EN
            r_chk        <= {HDR_MAGIC, r_seq};
`endif
          end
        end
        default: begin
          if (w_fin) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_seq       <= r_seq + 16'd1;
            r_nidx      <= '0;
            r_state     <= ST_IDLE;
            r_reg_addr  <= '0;
            r_dmem_addr <= '0;
          end else if (w_load) begin
            r_data      <= w_word;
            r_last      <= (r_nidx == FRAME_LEN - 6'd1);
            r_nidx      <= w_n1;
            r_state     <= w_nst;
            r_reg_addr  <= w_raddr;
            r_dmem_addr <= w_maddr;
`ifdef DUMP_CHECKSUM_EN
            r_chk       <= r_chk ^ w_word;
`endif
          end
        end
      endcase
    end
  end

  assign reg_addr_o        = r_reg_addr;
  assign dmem_addr_o       = r_dmem_addr;
  assign busy_o            = r_busy;
  assign dump.dump_data_o  = r_data;
  assign dump.dump_valid_o = r_valid;
  assign dump.dump_last_o  = r_last;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// tb_cpu_state_dumper: random stimulus against a frame-level model.
// Builds each expected frame from counters, PC and memory arrays.
module tb_cpu_state_dumper;

`ifdef DUMP_CHECKSUM_EN
  localparam int LEN = 46;
`else
  localparam int LEN = 45;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall_evt = 1'b0;
  logic        flush_evt = 1'b0;
  logic [31:0] pc = '0;
  logic [4:0]  reg_addr;
  logic [4:0]  dmem_addr;
  logic [31:0] reg_data;
  logic [31:0] dmem_data;
  logic        busy;
  logic [31:0] regs [32];
  logic [31:0] dmem [32];

  cpu_state_dumper_if dif ();

  assign reg_data  = regs[reg_addr];
  assign dmem_data = dmem[dmem_addr];

  cpu_state_dumper dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start),
    .pc_i        (pc),
    .stall_evt_i (stall_evt),
    .flush_evt_i (flush_evt),
    .reg_addr_o  (reg_addr),
    .reg_data_i  (reg_data),
    .dmem_addr_o (dmem_addr),
    .dmem_data_i (dmem_data),
    .busy_o      (busy),
    .dump        (dif)
  );

  always #5 clk = ~clk;

  longint m_cyc, n_stall, n_flush;
  longint stall_base, stall_ofs;
  logic [15:0] m_seq;
  int n_checks = 0;
  int n_err = 0;
  logic [31:0] got [64];
  int n_got;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc   <= 0;
      n_stall <= 0;
      n_flush <= 0;
    end else begin
      m_cyc   <= m_cyc + 1;
      n_stall <= n_stall + longint'(stall_evt);
      n_flush <= n_flush + longint'(flush_evt);
    end
  end

  function automatic logic [31:0] sat32(input longint v);
    logic [63:0] u;
    u = 64'(v);
    if (v > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return u[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] g,
                     input logic [31:0] e);
    n_checks++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, g, e);
    end
  endtask

  task automatic clear_model();
    m_seq      = '0;
    stall_base = 0;
    stall_ofs  = 0;
  endtask

  task automatic do_reset();
    start     = 1'b0;
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 32; i++) begin
      regs[i] = $urandom;
      dmem[i] = $urandom;
    end
    regs[0] = '0;
  endtask

  task automatic run_frame(input bit rnd_ready, input int abort_at,
                           input bit busy_start, input bit rnd_evt);
    logic [31:0] ex [64];
    logic [31:0] x;
    logic [31:0] hd;
    logic        hl;
    bit          done;
    bit          stalled;
    bit          sent;
    done    = 0;
    stalled = 0;
    sent    = 0;
    hd      = '0;
    hl      = 1'b0;
    pc      = $urandom;
    ex[0] = {16'hD0D0, m_seq};
    ex[1] = sat32(m_cyc);
    ex[2] = sat32(stall_base + n_stall - stall_ofs);
    ex[3] = sat32(n_flush);
    ex[4] = pc;
    for (int i = 0; i < 32; i++) ex[5 + i] = regs[i];
    for (int i = 0; i < 8; i++) ex[37 + i] = dmem[i];
    x = '0;
    for (int i = 0; i < 45; i++) x = x ^ ex[i];
    ex[45] = x;
    if (rnd_evt) begin
      stall_evt = 1'($urandom_range(0, 1));
      flush_evt = 1'($urandom_range(0, 1));
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", 32'(busy), 32'd1);
    chk("lat1_valid", 32'(dif.dump_valid_o), 32'd1);
    n_got = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      stall_evt = rnd_evt ? 1'($urandom_range(0, 1)) : 1'b0;
      flush_evt = rnd_evt ? 1'($urandom_range(0, 1)) : 1'b0;
      start = busy_start && (n_got == 20) && !sent;
      if (start) sent = 1;
      dif.dump_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at == n_got) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(dif.dump_valid_o), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_last", 32'(dif.dump_last_o), 32'd0);
        start     = 1'b0;
        stall_evt = 1'b0;
        flush_evt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        return;
      end
      chk("valid_in_frame", 32'(dif.dump_valid_o), 32'd1);
      if (stalled) begin
        chk("hold_data", dif.dump_data_o, hd);
        chk("hold_last", 32'(dif.dump_last_o), 32'(hl));
      end
      if (dif.dump_valid_o && dif.dump_ready_i) begin
        got[n_got] = dif.dump_data_o;
        chk("last_flag", 32'(dif.dump_last_o), 32'(n_got == LEN - 1));
        if (n_got == LEN - 1) done = 1;
        n_got++;
      end
      stalled = dif.dump_valid_o && !dif.dump_ready_i;
      hd = dif.dump_data_o;
      hl = dif.dump_last_o;
      @(negedge clk);
    end
    start     = 1'b0;
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    chk("frame_done", 32'(done), 32'd1);
    chk("busy_off", 32'(busy), 32'd0);
    chk("valid_off", 32'(dif.dump_valid_o), 32'd0);
    if (done) begin
      for (int i = 0; i < LEN; i++) begin
        chk($sformatf("w%0d", i), got[i], ex[i]);
      end
      m_seq = m_seq + 16'd1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.dump_ready_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      regs[i] = '0;
      dmem[i] = '0;
    end
    clear_model();
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(dif.dump_valid_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last", 32'(dif.dump_last_o), 32'd0);
    chk("rst_data", dif.dump_data_o, 32'd0);
    chk("rst_raddr", 32'(reg_addr), 32'd0);
    chk("rst_maddr", 32'(dmem_addr), 32'd0);

    // Basic frame with back-to-back transfers
    do_reset();
    regs[1] = 32'd5;
    regs[2] = 32'hFFFF_FFFD;
    dmem[0] = 32'd5;
    run_frame(1'b0, -1, 1'b0, 1'b0);
    chk("t1_w0", got[0], 32'hD0D0_0000);
    chk("t1_w6", got[6], 32'd5);
    chk("t1_w7", got[7], 32'hFFFF_FFFD);
    chk("t1_w37", got[37], 32'd5);

    // Back-pressure and random events
    rand_mem();
    run_frame(1'b1, -1, 1'b0, 1'b1);

    // Event counts; start while busy is ignored
    do_reset();
    rand_mem();
    repeat (3) begin
      stall_evt = 1'b1;
      @(negedge clk);
      stall_evt = 1'b0;
      @(negedge clk);
    end
    repeat (2) begin
      flush_evt = 1'b1;
      @(negedge clk);
      flush_evt = 1'b0;
      @(negedge clk);
    end
    run_frame(1'b0, -1, 1'b1, 1'b0);
    chk("t3_w2", got[2], 32'd3);
    chk("t3_w3", got[3], 32'd2);
    run_frame(1'b1, -1, 1'b0, 1'b0);
    chk("t3_seq1", got[0], 32'hD0D0_0001);

    // Reset in the middle of a frame
    run_frame(1'b0, 10, 1'b0, 1'b0);
    @(negedge clk);
    run_frame(1'b0, -1, 1'b0, 1'b0);
    chk("t4_seq0", got[0], 32'hD0D0_0000);

    // Random frames
    for (int f = 0; f < 4; f++) begin
      rand_mem();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame(1'($urandom_range(0, 1)), -1, 1'b0, 1'b1);
    end

    // Stall counter saturation
    force dut.u_stall_cnt.r_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.r_cnt;
    stall_base = 64'hFFFF_FFFE;
    stall_ofs  = n_stall;
    repeat (3) begin
      stall_evt = 1'b1;
      @(negedge clk);
      stall_evt = 1'b0;
      @(negedge clk);
    end
    run_frame(1'b0, -1, 1'b0, 1'b0);
    chk("t5_sat", got[2], 32'hFFFF_FFFF);

`ifdef DUMP_CHECKSUM_EN
    // Checksum on an all-zero state
    do_reset();
    for (int i = 0; i < 32; i++) begin
      regs[i] = '0;
      dmem[i] = '0;
    end
    run_frame(1'b0, -1, 1'b0, 1'b0);
    begin
      logic [31:0] xs;
      xs = '0;
      for (int i = 0; i < 45; i++) xs = xs ^ got[i];
      chk("t6_chk", got[45], xs);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
